// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron scheduler.
//   LIF_STATE_W : default membrane / current / threshold width
//   lif_state_e : scheduler FSM states
//   sat_add     : unsigned add clamped to 2^w-1 (operands must already fit in w bits)
package lif_pkg;

  localparam int unsigned LIF_STATE_W = 6;
  localparam int unsigned SAT_MAX_W   = 16;
  localparam int unsigned SAT_SUM_W   = SAT_MAX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UPDATE,
    EMIT
  } lif_state_e;

  // One extra carry bit is enough because both operands are below 2^w.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input int unsigned          w);
    logic [SAT_SUM_W-1:0] sum;
    logic [SAT_SUM_W-1:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (SAT_SUM_W'(1) << w) - SAT_SUM_W'(1);
    return (sum > lim) ? SAT_MAX_W'(lim) : SAT_MAX_W'(sum);
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky-integrate-and-fire step for one neuron.
//   i_v       : membrane value before the step
//   i_mbox    : accumulated input current for this step
//   i_thr     : firing threshold (0 = neuron disabled)
//   i_refract : refractory flag (only with LIF_SCHED_REFRACT_EN)
//   o_vn_wb   : membrane value to write back (0 after a spike)
//   o_fire    : neuron fires this step
// Optional feature macro: LIF_SCHED_REFRACT_EN
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int unsigned STATE_W = LIF_STATE_W
) (
  input  logic [STATE_W-1:0] i_v,
  input  logic [STATE_W-1:0] i_mbox,
  input  logic [STATE_W-1:0] i_thr,
`ifdef LIF_SCHED_REFRACT_EN
  input  logic               i_refract,
`endif
  output logic [STATE_W-1:0] o_vn_wb,
  output logic               o_fire
);

  logic [STATE_W-1:0] w_vn;
  logic               w_fire;

  // Leak is a halving of the old membrane; input current is added on top.
  always_comb begin
    w_vn   = STATE_W'(sat_add(SAT_MAX_W'(i_mbox), SAT_MAX_W'(i_v >> 1), STATE_W));
    w_fire = (i_thr != '0) && (w_vn >= i_thr);
`ifdef LIF_SCHED_REFRACT_EN
    // Refractory step: mailbox is thrown away and the membrane stays at rest.
    if (i_refract) begin
      w_fire = 1'b0;
      w_vn   = '0;
    end
`endif
    o_fire  = w_fire;
    o_vn_wb = w_fire ? '0 : w_vn;
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed LIF scheduler: one shared update datapath swept round-robin
// over N_NEURONS virtual neurons, spikes emitted as index events.
//   clk, reset             : clock, asynchronous active-high reset
//   run                    : keep sweeping; when low the current sweep finishes, then idle
//   in_valid/in_ready      : current-write handshake (in_idx, in_current)
//   thr_we/thr_idx/thr_value : threshold write, always accepted
//   spk_valid/spk_ready    : spike event stream, spk_idx = spiking neuron
//   mon_state              : membrane value written back by the last update
//   busy                   : FSM not idle
//   sweep_done             : one-cycle pulse after the last neuron of a sweep
// in_ready is combinational: it only drops when a write targets the neuron being loaded.
// Optional feature macro: LIF_SCHED_REFRACT_EN (per-neuron refractory bit)
module lif_neuron_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned STATE_W   = LIF_STATE_W,
  parameter int unsigned THR_RESET = 32,
  localparam int unsigned IDX_W    = $clog2(N_NEURONS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [STATE_W-1:0] in_current,
  input  logic               thr_we,
  input  logic [IDX_W-1:0]   thr_idx,
  input  logic [STATE_W-1:0] thr_value,
  output logic               spk_valid,
  input  logic               spk_ready,
  output logic [IDX_W-1:0]   spk_idx,
  output logic [STATE_W-1:0] mon_state,
  output logic               busy,
  output logic               sweep_done
);

  lif_state_e         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [STATE_W-1:0] r_v    [N_NEURONS];
  logic [STATE_W-1:0] r_mbox [N_NEURONS];
  logic [STATE_W-1:0] r_thr  [N_NEURONS];
  logic [STATE_W-1:0] r_v_cur;
  logic [STATE_W-1:0] r_mb_cur;
  logic [STATE_W-1:0] r_thr_cur;
`ifdef LIF_SCHED_REFRACT_EN
  logic [N_NEURONS-1:0] r_refract;
  logic                 r_ref_cur;
`endif

  logic [STATE_W-1:0] w_vn_wb;
  logic               w_fire;
  logic               w_in_acc;
  logic               w_last;
  logic [IDX_W-1:0]   w_next_idx;
  lif_state_e         w_adv_state;

  // A write to the neuron being loaded would race the mailbox clear; sender retries.
  assign in_ready = !((r_state == LOAD) && (in_idx == r_idx));
  assign w_in_acc = in_valid && in_ready;

  // Advance step shared by a non-firing UPDATE and an EMIT handshake.
  assign w_last      = (r_idx == IDX_W'(N_NEURONS - 1));
  assign w_next_idx  = w_last ? '0 : r_idx + IDX_W'(1);
  assign w_adv_state = (w_last && !run) ? IDLE : LOAD;

  lif_update_unit #(
    .STATE_W (STATE_W)
  ) u_update (
    .i_v       (r_v_cur),
    .i_mbox    (r_mb_cur),
    .i_thr     (r_thr_cur),
`ifdef LIF_SCHED_REFRACT_EN
    .i_refract (r_ref_cur),
`endif
    .o_vn_wb   (w_vn_wb),
    .o_fire    (w_fire)
  );

  // Mailbox: saturating accumulate of accepted writes, cleared when its neuron is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) r_mbox[IDX_W'(i)] <= '0;
    end else begin
      if (w_in_acc)
        r_mbox[in_idx] <= STATE_W'(sat_add(SAT_MAX_W'(r_mbox[in_idx]),
                                           SAT_MAX_W'(in_current), STATE_W));
      if (r_state == LOAD) r_mbox[r_idx] <= '0;
    end
  end

  // Thresholds: a write in the same LOAD cycle is seen from the next sweep on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) r_thr[IDX_W'(i)] <= STATE_W'(THR_RESET);
    end else if (thr_we) begin
      r_thr[thr_idx] <= thr_value;
    end
  end

  // Sweep FSM, membrane storage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_v_cur    <= '0;
      r_mb_cur   <= '0;
      r_thr_cur  <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) r_v[IDX_W'(i)] <= '0;
`ifdef LIF_SCHED_REFRACT_EN
      r_refract  <= '0;
      r_ref_cur  <= 1'b0;
`endif
      spk_valid  <= 1'b0;
      spk_idx    <= '0;
      mon_state  <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (run) begin
            r_state <= LOAD;
            r_idx   <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          r_v_cur   <= r_v[r_idx];
          r_mb_cur  <= r_mbox[r_idx];
          r_thr_cur <= r_thr[r_idx];
`ifdef LIF_SCHED_REFRACT_EN
          r_ref_cur <= r_refract[r_idx];
`endif
          r_state   <= UPDATE;
        end
        UPDATE: begin
          r_v[r_idx] <= w_vn_wb;
          mon_state  <= w_vn_wb;
`ifdef LIF_SCHED_REFRACT_EN
          // Set on fire; a refractory step never fires, so this also clears it.
          r_refract[r_idx] <= w_fire;
`endif
          if (w_fire) begin
            r_state   <= EMIT;
            spk_valid <= 1'b1;
            spk_idx   <= r_idx;
          end else begin
            r_state    <= w_adv_state;
            r_idx      <= w_next_idx;
            busy       <= (w_adv_state != IDLE);
            sweep_done <= w_last;
          end
        end
        EMIT: begin
          if (spk_ready) begin
            spk_valid  <= 1'b0;
            r_state    <= w_adv_state;
            r_idx      <= w_next_idx;
            busy       <= (w_adv_state != IDLE);
            sweep_done <= w_last;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench for lif_neuron_scheduler (N_NEURONS=4, STATE_W=6, THR_RESET=32).
module tb_lif_neuron_scheduler;

  logic       clk;
  logic       reset;
  logic       run;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_idx;
  logic [5:0] in_current;
  logic       thr_we;
  logic [1:0] thr_idx;
  logic [5:0] thr_value;
  logic       spk_valid;
  logic       spk_ready;
  logic [1:0] spk_idx;
  logic [5:0] mon_state;
  logic       busy;
  logic       sweep_done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LIF_SCHED_REFRACT_EN
  localparam logic [3:0] REFIRE_MASK = 4'b0000;
`else
  localparam logic [3:0] REFIRE_MASK = 4'b0010;
`endif

  lif_neuron_scheduler #(
    .N_NEURONS (4),
    .STATE_W   (6),
    .THR_RESET (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_current (in_current),
    .thr_we     (thr_we),
    .thr_idx    (thr_idx),
    .thr_value  (thr_value),
    .spk_valid  (spk_valid),
    .spk_ready  (spk_ready),
    .spk_idx    (spk_idx),
    .mon_state  (mon_state),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       w1_en;
    logic [1:0] w1_idx;
    logic [5:0] w1_cur;
    logic       w2_en;
    logic [1:0] w2_idx;
    logic [5:0] w2_cur;
    logic       t_en;
    logic [1:0] t_idx;
    logic [5:0] t_val;
    logic [3:0] mask;
    logic [5:0] mon2;
    logic [5:0] mon3;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input int w1i, input int w1c, input int w2i, input int w2c,
                              input int ti, input int tv, input logic [3:0] m,
                              input int m2, input int m3);
    vec_t v;
    v.w1_en  = (w1i >= 0);
    v.w1_idx = 2'(w1i);
    v.w1_cur = 6'(w1c);
    v.w2_en  = (w2i >= 0);
    v.w2_idx = 2'(w2i);
    v.w2_cur = 6'(w2c);
    v.t_en   = (ti >= 0);
    v.t_idx  = 2'(ti);
    v.t_val  = 6'(tv);
    v.mask   = m;
    v.mon2   = 6'(m2);
    v.mon3   = 6'(m3);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic write_cur(input logic [1:0] idx, input logic [5:0] cur);
    @(negedge clk);
    in_idx     = idx;
    in_current = cur;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  task automatic write_thr(input logic [1:0] idx, input logic [5:0] val);
    @(negedge clk);
    thr_idx   = idx;
    thr_value = val;
    thr_we    = 1'b1;
    @(negedge clk);
    thr_we    = 1'b0;
  endtask

  // One sweep from idle with run pulsed; sample j is taken after the j-th edge
  // counted from the one that leaves IDLE. With spk_ready=1 each spike costs one cycle.
  task automatic run_sweep(input string tag, input logic [3:0] mask,
                           input logic [5:0] m2, input logic [5:0] m3);
    int         i2;
    int         i3;
    int         idone;
    int         nspk;
    logic [3:0] seen;
    bit         done;
    i2    = 6 + $countones(mask[1:0]);
    i3    = 8 + $countones(mask[2:0]);
    idone = 8 + $countones(mask);
    nspk  = 0;
    seen  = '0;
    done  = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 24 && !done; j++) begin
      @(negedge clk);
      run = 1'b0;
      if (j == i2) chk({tag, " mon n2"}, 32'(mon_state), 32'(m2));
      if (j == i3) chk({tag, " mon n3"}, 32'(mon_state), 32'(m3));
      if (spk_valid && spk_ready) begin
        seen[spk_idx] = 1'b1;
        nspk++;
        chk({tag, " mon at spike"}, 32'(mon_state), 32'd0);
      end
      if (sweep_done) begin
        done = 1'b1;
        chk({tag, " sweep_done cycle"}, 32'(j), 32'(idone));
        chk({tag, " busy at end"}, 32'(busy), 32'd0);
      end
    end
    chk({tag, " sweep finished"}, 32'(done), 32'd1);
    chk({tag, " spike mask"}, 32'(seen), 32'(mask));
    chk({tag, " spike count"}, 32'(nspk), 32'($countones(mask)));
  endtask

  initial begin
    int   pulses;
    int   last;
    bit   spk_any;
    bit   mon_nz;
    bit   idle_seen;
    bit   found;
    int   cnt;
    reset      = 1'b1;
    run        = 1'b0;
    in_valid   = 1'b0;
    in_idx     = '0;
    in_current = '0;
    thr_we     = 1'b0;
    thr_idx    = '0;
    thr_value  = '0;
    spk_ready  = 1'b1;

    vecs[0]  = mk(1, 40, -1, 0, -1, 0, 4'b0010, 0, 0);
    vecs[1]  = mk(2, 20, -1, 0, -1, 0, 4'b0000, 20, 0);
    vecs[2]  = mk(2, 20, -1, 0, -1, 0, 4'b0000, 30, 0);
    vecs[3]  = mk(2, 20, -1, 0, -1, 0, 4'b0100, 0, 0);
    vecs[4]  = mk(3, 30, 3, 40, 3, 0, 4'b0000, 0, 63);
    vecs[5]  = mk(-1, 0, -1, 0, -1, 0, 4'b0000, 0, 31);
    vecs[6]  = mk(0, 63, 3, 10, -1, 0, 4'b0001, 0, 25);
    vecs[7]  = mk(2, 32, -1, 0, 3, 1, 4'b1100, 0, 0);
    vecs[8]  = mk(1, 40, -1, 0, -1, 0, 4'b0010, 0, 0);
    vecs[9]  = mk(1, 40, -1, 0, -1, 0, REFIRE_MASK, 0, 0);
    vecs[10] = mk(1, 40, -1, 0, -1, 0, 4'b0010, 0, 0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset spk_valid", 32'(spk_valid), 32'd0);
    chk("reset spk_idx", 32'(spk_idx), 32'd0);
    chk("reset mon_state", 32'(mon_state), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset sweep_done", 32'(sweep_done), 32'd0);

    // Free-running sweeps with no input: 8-cycle period, no spikes
    reset     = 1'b0;
    run       = 1'b1;
    pulses    = 0;
    last      = 0;
    spk_any   = 1'b0;
    mon_nz    = 1'b0;
    idle_seen = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (spk_valid) spk_any = 1'b1;
      if (mon_state != '0) mon_nz = 1'b1;
      if (!busy) idle_seen = 1'b1;
      if (sweep_done) begin
        if (pulses == 0) chk("first sweep_done cycle", 32'(j), 32'd8);
        else             chk("sweep_done period", 32'(j - last), 32'd8);
        pulses++;
        last = j;
      end
    end
    chk("sweep_done count", 32'(pulses), 32'd4);
    chk("idle spk_valid seen", 32'(spk_any), 32'd0);
    chk("idle mon nonzero", 32'(mon_nz), 32'd0);
    chk("busy dropped while running", 32'(idle_seen), 32'd0);
    run = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("stop after run low", 32'(busy), 32'd0);

    // Table-driven sweeps
    for (int k = 0; k < 11; k++) begin
      if (vecs[k].w1_en) write_cur(vecs[k].w1_idx, vecs[k].w1_cur);
      if (vecs[k].w2_en) write_cur(vecs[k].w2_idx, vecs[k].w2_cur);
      if (vecs[k].t_en)  write_thr(vecs[k].t_idx, vecs[k].t_val);
      run_sweep($sformatf("vec%0d", k), vecs[k].mask, vecs[k].mon2, vecs[k].mon3);
    end

    // Write colliding with LOAD of its own neuron is held off and lands next sweep
    @(negedge clk);
    run        = 1'b1;
    in_idx     = 2'd1;
    in_current = 6'd40;
    in_valid   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    chk("in_ready LOAD n0, idx1", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("in_ready LOAD n1, idx1", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready UPDATE n1", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready LOAD n2, idx1", 32'(in_ready), 32'd1);
    spk_any = 1'b0;
    cnt     = 0;
    while (busy && cnt < 20) begin
      @(negedge clk);
      if (spk_valid) spk_any = 1'b1;
      cnt++;
    end
    chk("retry sweep idle", 32'(busy), 32'd0);
    chk("retry sweep spike", 32'(spk_any), 32'd0);
    run_sweep("late write", 4'b0010, 0, 0);

    // Back-pressure: spike held stable for 5 cycles, handshake on the 6th
    spk_ready = 1'b0;
    write_cur(2'd0, 6'd63);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    found = 1'b0;
    for (int j = 0; j < 10 && !found; j++) begin
      @(negedge clk);
      run = 1'b0;
      if (spk_valid) found = 1'b1;
    end
    chk("stall spike seen", 32'(found), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall spk_valid", 32'(spk_valid), 32'd1);
      chk("stall spk_idx", 32'(spk_idx), 32'd0);
      chk("stall busy", 32'(busy), 32'd1);
      chk("stall sweep_done", 32'(sweep_done), 32'd0);
    end
    spk_ready = 1'b1;
    @(negedge clk);
    chk("stall released", 32'(spk_valid), 32'd0);
    cnt = 0;
    while (!sweep_done && cnt < 16) begin
      @(negedge clk);
      cnt++;
    end
    chk("stall sweep_done delay", 32'(cnt), 32'd6);
    @(negedge clk);

    // Reset in the middle of EMIT drops the spike and restores thresholds
    spk_ready = 1'b0;
    write_cur(2'd2, 6'd63);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    found = 1'b0;
    for (int j = 0; j < 12 && !found; j++) begin
      @(negedge clk);
      run = 1'b0;
      if (spk_valid) found = 1'b1;
    end
    chk("pre-reset spk_idx", 32'(spk_idx), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid-emit reset spk_valid", 32'(spk_valid), 32'd0);
    chk("mid-emit reset busy", 32'(busy), 32'd0);
    chk("mid-emit reset mon_state", 32'(mon_state), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    spk_ready = 1'b1;
    write_cur(2'd3, 6'd5);
    run_sweep("post reset", 4'b0000, 0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
